// File: rtl/reset_sequencer_pkg.sv
// Shared types and helpers for the reset sequencer: FSM state encoding and
// the counter width calculation.
package reset_sequencer_pkg;

    // Debug-visible FSM state encoding (also driven onto the state output)
    typedef enum logic [2:0] {
        HOLD   = 3'd0,
        SETTLE = 3'd1,
        CALIB  = 3'd2,
        RUN    = 3'd3,
        FAIL   = 3'd4
    } rseq_state_t;

    // Counter width large enough to hold the larger of the two terminal counts
    function automatic int rseq_cnt_width(input int settle_cycles, input int calib_timeout);
        int max_v;
        max_v = (settle_cycles > calib_timeout) ? settle_cycles : calib_timeout;
        return (max_v > 1) ? $clog2(max_v) : 1;
    endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Bundle of the sequencer's calibration input and reset/status outputs.
// slave: the sequencer side; master: the system/bench side.
interface reset_sequencer_if
    import reset_sequencer_pkg::*;
();
    logic        calib_done;
    logic        mig_rst_n;
    logic        core_rst_n;
    rseq_state_t state;
    logic [1:0]  retries;
    logic        fail;

    modport slave (
        input  calib_done,
        output mig_rst_n,
        output core_rst_n,
        output state,
        output retries,
        output fail
    );

    modport master (
        output calib_done,
        input  mig_rst_n,
        input  core_rst_n,
        input  state,
        input  retries,
        input  fail
    );
endinterface

// File: rtl/reset_sequencer_sync_ff.sv
// Multi-stage bit synchronizer with asynchronous active-low clear. Used both
// for the asynchronous calib_done input and, with d tied high, as the
// reset-release chain (assert immediately, release after SYNC_STAGES edges).
module sync_ff #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic clr_n,
    input  logic d,
    output logic q
);
    logic [SYNC_STAGES-1:0] stage_q;
    logic [SYNC_STAGES-1:0] stage_d;

    // Shift the input one stage further along the chain each cycle
    always_comb begin
        stage_d = {stage_q[SYNC_STAGES-2:0], d};
    end

    // Synchronizer flops, cleared asynchronously
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign q = stage_q[SYNC_STAGES-1];
endmodule

// File: rtl/reset_sequencer.sv
// Reset sequencer: turns MMCM locked (reset_n) into ordered DDR3-controller
// and core resets, watches calibration with timeout/retry and a sticky fail.
module reset_sequencer
    import reset_sequencer_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int SETTLE_CYCLES = 1024,
    parameter int CALIB_TIMEOUT = 1048576,
    parameter int MAX_RETRIES   = 3
) (
    input  logic             clk_core,
    input  logic             reset_n,
    reset_sequencer_if.slave bus
);
    localparam int               CNT_W       = rseq_cnt_width(SETTLE_CYCLES, CALIB_TIMEOUT);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CALIB_LAST  = CNT_W'(CALIB_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    // retries is only two bits wide, so the retry limit saturates at 3
    localparam logic [1:0]       RETRY_MAX   = (MAX_RETRIES > 3) ? 2'd3 : 2'(MAX_RETRIES);

    logic rst_int_n;
    logic calib_s;

    rseq_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       retries_q, retries_d;
    logic             mig_rst_n_q, mig_rst_n_d;
    logic             core_rst_n_q, core_rst_n_d;
    logic             fail_q, fail_d;

    // Internal reset: asserts with reset_n, releases SYNC_STAGES edges later
    sync_ff #(.SYNC_STAGES(SYNC_STAGES)) u_rst_sync (
        .clk   (clk_core),
        .clr_n (reset_n),
        .d     (1'b1),
        .q     (rst_int_n)
    );

    // calib_done crosses into clk_core here
    sync_ff #(.SYNC_STAGES(SYNC_STAGES)) u_calib_sync (
        .clk   (clk_core),
        .clr_n (rst_int_n),
        .d     (bus.calib_done),
        .q     (calib_s)
    );

    // Next-state, counter and retry logic; outputs derive from the next state
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        retries_d = retries_q;
        case (state_q)
            HOLD: begin
                state_d = SETTLE;
                cnt_d   = '0;
            end
            SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = CALIB;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            CALIB: begin
                // A calibration arriving on the timeout cycle still wins
                if (calib_s) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else if (cnt_q == CALIB_LAST) begin
                    cnt_d = '0;
                    if (retries_q < RETRY_MAX) begin
                        retries_d = retries_q + 2'd1;
                        state_d   = SETTLE;
                    end else begin
                        state_d = FAIL;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            RUN: begin
                cnt_d = '0;
                if (!calib_s) begin
                    state_d = SETTLE;
                end else begin
                    state_d = RUN;
                end
            end
            FAIL: begin
                state_d = FAIL;
                cnt_d   = '0;
            end
            default: begin
                state_d = HOLD;
                cnt_d   = '0;
            end
        endcase
        mig_rst_n_d  = (state_d == CALIB) || (state_d == RUN);
        core_rst_n_d = (state_d == RUN);
        fail_d       = (state_d == FAIL);
    end

    // FSM state, counter and registered reset/status outputs
    always_ff @(posedge clk_core or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q      <= HOLD;
            cnt_q        <= '0;
            retries_q    <= 2'd0;
            mig_rst_n_q  <= 1'b0;
            core_rst_n_q <= 1'b0;
            fail_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            retries_q    <= retries_d;
            mig_rst_n_q  <= mig_rst_n_d;
            core_rst_n_q <= core_rst_n_d;
            fail_q       <= fail_d;
        end
    end

    assign bus.mig_rst_n  = mig_rst_n_q;
    assign bus.core_rst_n = core_rst_n_q;
    assign bus.state      = state_q;
    assign bus.retries    = retries_q;
    assign bus.fail       = fail_q;
endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer with short timing parameters. Cycle n means
// "after the n-th rising edge following reset_n release"; reset_n is released
// on a falling edge, so edge 1 is the first rising edge after release.
module tb_reset_sequencer;

    logic clk_core = 1'b0;
    logic reset_n  = 1'b0;

    reset_sequencer_if bus_if ();

    reset_sequencer #(
        .SYNC_STAGES   (2),
        .SETTLE_CYCLES (8),
        .CALIB_TIMEOUT (16),
        .MAX_RETRIES   (2)
    ) dut (
        .clk_core (clk_core),
        .reset_n  (reset_n),
        .bus      (bus_if)
    );

    always #5 clk_core = ~clk_core;

    typedef struct {
        string      name;
        logic       mig;
        logic       core;
        logic [2:0] st;
        logic [1:0] ret;
        logic       chk_ret;
        logic       fl;
    } exp_t;

    typedef struct {
        int   rise;
        int   fall;
        int   rise2;
        int   check;
        exp_t e;
    } vec_t;

    vec_t vec_q[$];
    exp_t exp_q[$];
    int   cyc;
    int   checks = 0;
    int   errors = 0;

    task automatic add(input string name, input int rise, input int fall, input int rise2,
                       input int check, input logic mig, input logic core, input logic [2:0] st,
                       input logic [1:0] ret, input logic chk_ret, input logic fl);
        vec_t v;
        v.rise = rise; v.fall = fall; v.rise2 = rise2; v.check = check;
        v.e = '{name, mig, core, st, ret, chk_ret, fl};
        vec_q.push_back(v);
    endtask

    task automatic expect_now(input string name, input logic mig, input logic core,
                              input logic [2:0] st, input logic [1:0] ret, input logic fl);
        exp_t e;
        e = '{name, mig, core, st, ret, 1'b1, fl};
        exp_q.push_back(e);
    endtask

    task automatic check_pop();
        exp_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard: got empty expectation queue, want an entry");
        end else begin
            e = exp_q.pop_front();
            if (bus_if.mig_rst_n !== e.mig || bus_if.core_rst_n !== e.core ||
                3'(bus_if.state) !== e.st || bus_if.fail !== e.fl ||
                (e.chk_ret && bus_if.retries !== e.ret)) begin
                errors++;
                $display("FAIL %s: got mig=%b core=%b state=%0d retries=%0d fail=%b, want mig=%b core=%b state=%0d retries=%0d fail=%b",
                         e.name, bus_if.mig_rst_n, bus_if.core_rst_n, 3'(bus_if.state),
                         bus_if.retries, bus_if.fail, e.mig, e.core, e.st, e.ret, e.fl);
            end
        end
    endtask

    task automatic release_reset();
        bus_if.calib_done = 1'b0;
        reset_n = 1'b0;
        repeat (3) @(negedge clk_core);
        reset_n = 1'b1;
        cyc = 0;
    endtask

    task automatic step_to(input int target, input int rise, input int fall, input int rise2);
        while (cyc < target) begin
            @(posedge clk_core);
            @(negedge clk_core);
            cyc++;
            if (cyc == rise)  bus_if.calib_done = 1'b1;
            if (cyc == fall)  bus_if.calib_done = 1'b0;
            if (cyc == rise2) bus_if.calib_done = 1'b1;
        end
    endtask

    // Pull reset_n low between clock edges and sample before any edge occurs
    task automatic async_reset_pulse();
        @(posedge clk_core);
        #3;
        reset_n = 1'b0;
        #1;
    endtask

    initial begin
        bus_if.calib_done = 1'b0;

        // name, rise, fall, rise2, check, mig, core, state, retries, chk_ret, fail
        add("hold_e1",        -1, -1, -1,  1, 1'b0, 1'b0, 3'd0, 2'd0, 1'b1, 1'b0);
        add("hold_e2",        -1, -1, -1,  2, 1'b0, 1'b0, 3'd0, 2'd0, 1'b1, 1'b0);
        add("settle_entry",   -1, -1, -1,  3, 1'b0, 1'b0, 3'd1, 2'd0, 1'b1, 1'b0);
        add("settle_last",    -1, -1, -1, 10, 1'b0, 1'b0, 3'd1, 2'd0, 1'b1, 1'b0);
        add("mig_rise",       -1, -1, -1, 11, 1'b1, 1'b0, 3'd2, 2'd0, 1'b1, 1'b0);
        add("core_pre",       20, -1, -1, 22, 1'b1, 1'b0, 3'd2, 2'd0, 1'b1, 1'b0);
        add("core_rise",      20, -1, -1, 23, 1'b1, 1'b1, 3'd3, 2'd0, 1'b1, 1'b0);
        add("calib1_last",    -1, -1, -1, 26, 1'b1, 1'b0, 3'd2, 2'd0, 1'b1, 1'b0);
        add("timeout1",       -1, -1, -1, 27, 1'b0, 1'b0, 3'd1, 2'd1, 1'b1, 1'b0);
        add("retry_pre",      40, -1, -1, 42, 1'b1, 1'b0, 3'd2, 2'd1, 1'b1, 1'b0);
        add("retry_run",      40, -1, -1, 43, 1'b1, 1'b1, 3'd3, 2'd1, 1'b1, 1'b0);
        add("calib3_last",    -1, -1, -1, 74, 1'b1, 1'b0, 3'd2, 2'd2, 1'b1, 1'b0);
        add("fail_entry",     -1, -1, -1, 75, 1'b0, 1'b0, 3'd4, 2'd0, 1'b0, 1'b1);
        add("fail_sticky",    80, -1, -1, 90, 1'b0, 1'b0, 3'd4, 2'd0, 1'b0, 1'b1);
        add("loss_pre",       20, 30, -1, 32, 1'b1, 1'b1, 3'd3, 2'd0, 1'b1, 1'b0);
        add("loss",           20, 30, -1, 33, 1'b0, 1'b0, 3'd1, 2'd0, 1'b1, 1'b0);
        add("loss_calib",     20, 30, 35, 41, 1'b1, 1'b0, 3'd2, 2'd0, 1'b1, 1'b0);
        add("loss_rerun",     20, 30, 35, 42, 1'b1, 1'b1, 3'd3, 2'd0, 1'b1, 1'b0);
        add("collide",        24, -1, -1, 27, 1'b1, 1'b1, 3'd3, 2'd0, 1'b1, 1'b0);
        add("collide_late",   25, -1, -1, 27, 1'b0, 1'b0, 3'd1, 2'd1, 1'b1, 1'b0);

        // Outputs while reset_n is held low
        reset_n = 1'b0;
        repeat (3) @(negedge clk_core);
        expect_now("in_reset", 1'b0, 1'b0, 3'd0, 2'd0, 1'b0);
        check_pop();

        // Table: each vector restarts from reset and is checked at one cycle
        for (int i = 0; i < vec_q.size(); i++) begin
            release_reset();
            exp_q.push_back(vec_q[i].e);
            step_to(vec_q[i].check, vec_q[i].rise, vec_q[i].fall, vec_q[i].rise2);
            check_pop();
        end

        // Asynchronous reset in the middle of CALIB
        release_reset();
        step_to(15, -1, -1, -1);
        expect_now("mid_calib", 1'b1, 1'b0, 3'd2, 2'd0, 1'b0);
        check_pop();
        async_reset_pulse();
        expect_now("async_calib", 1'b0, 1'b0, 3'd0, 2'd0, 1'b0);
        check_pop();

        // Asynchronous reset in RUN after one retry, then a full restart
        release_reset();
        step_to(50, 40, -1, -1);
        expect_now("mid_run", 1'b1, 1'b1, 3'd3, 2'd1, 1'b0);
        check_pop();
        async_reset_pulse();
        expect_now("async_run", 1'b0, 1'b0, 3'd0, 2'd0, 1'b0);
        check_pop();
        @(negedge clk_core);
        reset_n = 1'b1;
        cyc = 0;
        step_to(11, -1, -1, -1);
        expect_now("restart_calib", 1'b1, 1'b0, 3'd2, 2'd0, 1'b0);
        check_pop();
        step_to(12, -1, -1, -1);
        expect_now("restart_run", 1'b1, 1'b1, 3'd3, 2'd0, 1'b0);
        check_pop();

        // Asynchronous reset clears the sticky failure
        release_reset();
        step_to(78, -1, -1, -1);
        exp_q.push_back('{"fail_hold", 1'b0, 1'b0, 3'd4, 2'd0, 1'b0, 1'b1});
        check_pop();
        async_reset_pulse();
        expect_now("async_fail", 1'b0, 1'b0, 3'd0, 2'd0, 1'b0);
        check_pop();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
